// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-side constants reused by fetch, decode and the branch unit.
// Also provides the address-wrap helper used for PC arithmetic.
package instruction_fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] WORD_STEP        = 32'd4;

  // rom_bytes is a power of two, so modulo reduces to a mask.
  function automatic logic [31:0] wrap_addr(input logic [31:0] addr,
                                            input logic [31:0] rom_bytes);
    return addr & (rom_bytes - 32'd1);
  endfunction
endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Program counter register: loads (fetch_addr + 4) mod ROM_BYTES each edge
// unless held; resets synchronously to RESET_PC.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned ROM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hold,
  input  logic [31:0] fetch_addr,
  output logic [31:0] pc
);
  logic [31:0] pc_d;
  logic [31:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (!hold) begin
      pc_d = wrap_addr(fetch_addr + WORD_STEP, 32'(ROM_BYTES));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the ROM address, aligns the ROM's registered word with
// its PC for IF/ID, handles stall replay, branch redirect and a fetch counter.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned ROM_BYTES = 1024
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic [INSTR_W-1:0] if_instruction,
  output logic               if_valid,
  output logic               misaligned,
  output logic [31:0]        fetch_count
);
  logic [31:0] pc;
  logic        hold;

  logic [31:0] if_pc_d, if_pc_q;
  logic        if_valid_d, if_valid_q;
  logic        misaligned_d, misaligned_q;
  logic [31:0] fetch_count_d, fetch_count_q;

  // A branch overrides a stall, so only a branch-free stall holds state.
  assign hold = stall & ~branch_taken;

  always_comb begin
    rom_address = pc;
    if (!reset_n) begin
      rom_address = RESET_PC;
    end else if (branch_taken) begin
      rom_address = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      rom_address = if_pc_q;
    end
  end

  fetch_pc_reg #(
    .RESET_PC  (RESET_PC),
    .ROM_BYTES (ROM_BYTES)
  ) u_pc_reg (
    .clock      (clock),
    .reset_n    (reset_n),
    .hold       (hold),
    .fetch_addr (rom_address),
    .pc         (pc)
  );

  always_comb begin
    if_pc_d       = rom_address;
    if_valid_d    = hold ? if_valid_q : 1'b1;
    misaligned_d  = misaligned_q | (branch_taken & (branch_target[1:0] != 2'b00));
    fetch_count_d = fetch_count_q;
    if (if_valid_q && !stall) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      if_pc_q       <= 32'd0;
      if_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = wrap_addr(if_pc_q + WORD_STEP, 32'(ROM_BYTES));
  assign if_instruction = if_valid_q ? rom_instruction : '0;
  assign if_valid       = if_valid_q;
  assign misaligned     = misaligned_q;
  assign fetch_count    = fetch_count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a registered ROM model, directed steps and
// a randomized phase, all checked against a transaction-level fetch model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned ROM_BYTES = 1024;
  localparam int unsigned ROM_WORDS = ROM_BYTES / 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] rom_address;
  logic [31:0] rom_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        misaligned;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom_mem [ROM_WORDS];

  // Reference model state: what the fetch stage should hold, in spec terms.
  logic [31:0] m_next_pc;
  logic [31:0] m_if_pc;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_count;
  logic [31:0] m_addr;

  always #5 clock = ~clock;

  always @(posedge clock) rom_instruction <= rom_mem[rom_address[9:2]];

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .ROM_BYTES (ROM_BYTES)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instruction  (if_instruction),
    .if_valid        (if_valid),
    .misaligned      (misaligned),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check the address, clock, advance model, check IF/ID.
  task automatic step(input logic rst_n, input logic st, input logic br, input logic [31:0] tgt);
    reset_n       = rst_n;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    if (!rst_n)   m_addr = RESET_PC;
    else if (br)  m_addr = tgt & ~32'd3;
    else if (st)  m_addr = m_if_pc;
    else          m_addr = m_next_pc;
    check("rom_address", rom_address, m_addr);
    @(posedge clock);
    if (!rst_n) begin
      m_next_pc = RESET_PC;
      m_if_pc   = 32'd0;
      m_valid   = 1'b0;
      m_mis     = 1'b0;
      m_count   = 32'd0;
    end else begin
      if (m_valid && !st) m_count = m_count + 1;
      if (br && tgt[1:0] != 2'b00) m_mis = 1'b1;
      if (br || !st) begin
        m_next_pc = (m_addr + 4) % ROM_BYTES;
        m_valid   = 1'b1;
      end
      m_if_pc = m_addr;
    end
    #1;
    check("if_pc", if_pc, m_if_pc);
    check("if_pc_plus4", if_pc_plus4, (m_if_pc + 4) % ROM_BYTES);
    check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    check("if_instruction", if_instruction, m_valid ? rom_mem[m_if_pc / 4] : 32'd0);
    check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
    check("fetch_count", fetch_count, m_count);
  endtask

  initial begin
    for (int i = 0; i < int'(ROM_WORDS); i++) rom_mem[i] = $urandom;
    m_next_pc = RESET_PC;
    m_if_pc   = 32'd0;
    m_valid   = 1'b0;
    m_mis     = 1'b0;
    m_count   = 32'd0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    check("reset_if_valid", {31'd0, if_valid}, 32'd0);

    // Free-run from reset: 0, 4, 8.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("first_if_pc", if_pc, 32'h0);
    check("first_valid", {31'd0, if_valid}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("run_if_pc_8", if_pc, 32'h8);

    // Stall three cycles at if_pc=8, then release.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("stall_if_pc", if_pc, 32'h8);
      check("stall_count", fetch_count, 32'd2);
    end
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("release_if_pc", if_pc, 32'hC);
    check("release_count", fetch_count, 32'd3);

    // Branch with simultaneous stall: branch wins.
    step(1'b1, 1'b1, 1'b1, 32'h30);
    check("br_if_pc", if_pc, 32'h30);
    check("br_pc_plus4", if_pc_plus4, 32'h34);
    check("br_misaligned", {31'd0, misaligned}, 32'd0);

    // Misaligned target is aligned down and the flag sticks.
    step(1'b1, 1'b0, 1'b1, 32'h2E);
    check("mis_if_pc", if_pc, 32'h2C);
    check("mis_flag", {31'd0, misaligned}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("mis_sticky", {31'd0, misaligned}, 32'd1);

    // Wrap-around at the top of the ROM.
    step(1'b1, 1'b0, 1'b1, 32'h3FC);
    check("wrap_top", if_pc, 32'h3FC);
    check("wrap_plus4", if_pc_plus4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("wrap_zero", if_pc, 32'h0);

    // Reset during a stall at if_pc=0x14.
    step(1'b1, 1'b0, 1'b1, 32'h14);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("pre_reset_if_pc", if_pc, 32'h14);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("mid_reset_valid", {31'd0, if_valid}, 32'd0);
    check("mid_reset_count", fetch_count, 32'd0);
    check("mid_reset_mis", {31'd0, misaligned}, 32'd0);
    check("mid_reset_addr", rom_address, RESET_PC);

    // Stalled bubble stays a bubble after reset release.
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("bubble_valid", {31'd0, if_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic          r_rst, r_st, r_br;
      logic [31:0]   r_tgt;
      r_rst = ($urandom_range(0, 99) >= 3);
      r_st  = ($urandom_range(0, 99) < 30);
      r_br  = ($urandom_range(0, 99) < 15);
      r_tgt = $urandom_range(0, ROM_BYTES - 1);
      if ($urandom_range(0, 9) != 0) r_tgt[1:0] = 2'b00;
      step(r_rst, r_st, r_br, r_tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
